// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access.
// Data wins by default; a streak counter forces an inst grant to avoid starvation.
module sram_req_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    input  logic [3:0]  inst_wstrb,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t     state, state_nx;
    logic       owner, owner_nx;
    logic [3:0] streak, streak_nx;
    logic       sel_data, sel_inst;
    logic       gnt, fwd;

    assign sel_data = data_req && !(inst_req && streak == STREAK_MAX);
    assign sel_inst = !sel_data && inst_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            owner  <= 1'b0;
            streak <= 4'd0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            streak <= streak_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        owner_nx     = owner;
        streak_nx    = streak;
        gnt          = owner;
        fwd          = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = 2'd0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        mem_wstrb    = 4'd0;
        if (reset) begin
            unique case (state)
                IDLE: begin
                    if (sel_data || sel_inst) begin
                        gnt      = sel_data;
                        fwd      = 1'b1;
                        owner_nx = sel_data;
                        state_nx = mem_addr_ok ? WAIT : HOLD;
                    end
                end
                HOLD: begin
                    // a dropped owner request releases the lock without a grant
                    if (owner ? data_req : inst_req) begin
                        fwd = 1'b1;
                        if (mem_addr_ok) state_nx = WAIT;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                WAIT: begin
                    if (mem_data_ok) begin
                        state_nx = IDLE;
                        if (owner) begin
                            data_data_ok = 1'b1;
                            data_rdata   = mem_rdata;
                        end else begin
                            inst_data_ok = 1'b1;
                            inst_rdata   = mem_rdata;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
            if (fwd) begin
                mem_req      = 1'b1;
                mem_wr       = gnt ? data_wr    : inst_wr;
                mem_size     = gnt ? data_size  : inst_size;
                mem_addr     = gnt ? data_addr  : inst_addr;
                mem_wdata    = gnt ? data_wdata : inst_wdata;
                mem_wstrb    = gnt ? data_wstrb : inst_wstrb;
                data_addr_ok = gnt && mem_addr_ok;
                inst_addr_ok = !gnt && mem_addr_ok;
                if (mem_addr_ok) begin
                    if (gnt && inst_req)
                        streak_nx = (streak == STREAK_MAX) ? streak : streak + 4'd1;
                    else
                        streak_nx = 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter.
// Inputs change 1ns after posedge; outputs are checked 1ns later.
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic ed;

    localparam logic [31:0] IA = 32'h1C00_0000;
    localparam logic [31:0] DA = 32'h8000_1000;

    always #5 clk = ~clk;

    sram_req_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_wstrb(inst_wstrb),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2;
        inst_addr = IA; inst_wdata = 32'd0; inst_wstrb = 4'd0;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
        data_addr = DA; data_wdata = 32'd0; data_wstrb = 4'd0;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_iaok", inst_addr_ok, 0);
        chk("rst_daok", data_addr_ok, 0);
        chk("rst_mem_addr", mem_addr, 0);
        tick;

        // single inst read
        reset = 1'b1; data_req = 1'b0; mem_data_ok = 1'b0; #1;
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, IA);
        chk("t1_iaok", inst_addr_ok, 1);
        chk("t1_daok", data_addr_ok, 0);
        tick;
        inst_req = 1'b0; mem_addr_ok = 1'b0; #1;
        chk("t1_wait_req", mem_req, 0);
        chk("t1_wait_idok", inst_data_ok, 0);
        tick;
        mem_data_ok = 1'b1; mem_rdata = 32'h0280_0C0C; #1;
        chk("t1_idok", inst_data_ok, 1);
        chk("t1_irdata", inst_rdata, 32'h0280_0C0C);
        chk("t1_ddok", data_data_ok, 0);
        chk("t1_drdata", data_rdata, 0);
        tick;
        mem_data_ok = 1'b0; #1;
        chk("t1_idok_off", inst_data_ok, 0);
        chk("t1_irdata_off", inst_rdata, 0);

        // simultaneous requests: data first, inst after response
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; #1;
        chk("t2_mem_addr", mem_addr, DA);
        chk("t2_daok", data_addr_ok, 1);
        chk("t2_iaok", inst_addr_ok, 0);
        tick;
        data_req = 1'b0; #1;
        chk("t2_wait_req", mem_req, 0);
        chk("t2_wait_iaok", inst_addr_ok, 0);
        tick;
        mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222; #1;
        chk("t2_ddok", data_data_ok, 1);
        chk("t2_drdata", data_rdata, 32'h1111_2222);
        chk("t2_iaok_dok", inst_addr_ok, 0);
        tick;
        mem_data_ok = 1'b0; #1;
        chk("t2_inst_addr", mem_addr, IA);
        chk("t2_inst_iaok", inst_addr_ok, 1);
        tick;
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
        chk("t2_idok", inst_data_ok, 1);
        tick;

        // grant lock while memory stalls
        mem_data_ok = 1'b0; inst_req = 1'b1; data_req = 1'b1; #1;
        for (int c = 0; c < 3; c++) begin
            chk("t3_mem_addr", mem_addr, DA);
            chk("t3_iaok", inst_addr_ok, 0);
            chk("t3_daok", data_addr_ok, 0);
            tick;
            #0;
        end
        inst_req = 1'b0; mem_addr_ok = 1'b1; #1;
        chk("t3_accept", data_addr_ok, 1);
        chk("t3_accept_addr", mem_addr, DA);
        tick;
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; #1;
        chk("t3_ddok", data_data_ok, 1);
        tick;

        // starvation guard: d d d d i d d d d i
        for (int k = 0; k < 10; k++) begin
            ed = ((k % 5) != 4);
            inst_req = 1'b1; data_req = 1'b1;
            mem_addr_ok = 1'b1; mem_data_ok = 1'b0; #1;
            chk("t4_daok", data_addr_ok, ed);
            chk("t4_iaok", inst_addr_ok, !ed);
            chk("t4_addr", mem_addr, ed ? DA : IA);
            tick;
            mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = k; #1;
            chk("t4_ddok", data_data_ok, ed);
            chk("t4_idok", inst_data_ok, !ed);
            tick;
        end

        // byte store
        inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_wstrb = 4'b0100; data_wdata = 32'h00AB_0000;
        data_addr = 32'h8000_2002; mem_addr_ok = 1'b1; mem_data_ok = 1'b0; #1;
        chk("t5_wr", mem_wr, 1);
        chk("t5_size", mem_size, 0);
        chk("t5_wstrb", mem_wstrb, 4'b0100);
        chk("t5_wdata", mem_wdata, 32'h00AB_0000);
        chk("t5_addr", mem_addr, 32'h8000_2002);
        chk("t5_daok", data_addr_ok, 1);
        tick;
        data_req = 1'b0; mem_addr_ok = 1'b0; #1;
        chk("t5_ddok_early", data_data_ok, 0);
        tick;
        mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678; #1;
        chk("t5_ddok", data_data_ok, 1);
        chk("t5_drdata", data_rdata, 32'h1234_5678);
        tick;
        mem_data_ok = 1'b0; #1;
        chk("t5_ddok_once", data_data_ok, 0);

        // owner drops request while held
        data_wr = 1'b0; data_size = 2'd2; data_addr = DA; data_req = 1'b1; #1;
        chk("t7_hold_req", mem_req, 1);
        tick;
        data_req = 1'b0; inst_req = 1'b1; mem_addr_ok = 1'b1; #1;
        chk("t7_drop_req", mem_req, 0);
        chk("t7_drop_iaok", inst_addr_ok, 0);
        tick;
        #0;
        chk("t7_inst_after", inst_addr_ok, 1);
        chk("t7_inst_addr", mem_addr, IA);
        tick;

        // reset while waiting for the response
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        reset = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
        chk("t6_rst_idok", inst_data_ok, 0);
        chk("t6_rst_irdata", inst_rdata, 0);
        chk("t6_rst_mem_req", mem_req, 0);
        tick;
        reset = 1'b1; #1;
        chk("t6_stray_idok", inst_data_ok, 0);
        chk("t6_stray_ddok", data_data_ok, 0);
        chk("t6_stray_req", mem_req, 0);
        tick;
        inst_req = 1'b1; mem_data_ok = 1'b0; mem_addr_ok = 1'b1; #1;
        chk("t6_idle_grant", inst_addr_ok, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
Shares one SRAM-like memory port between the instruction-fetch requester (IF) and the data requester (EX load/store). Forwards one request at a time and locks the grant until the request is accepted. Routes the single outstanding response back to its owner. Priority is data over instruction, with a starvation guard for instruction fetch. Sits between the pipeline stages and the memory bridge.

Parameters:
MAX_DATA_STREAK, 4, consecutive data grants allowed while inst_req is pending before inst is forced (1..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset (reset==0 resets)
inst_req / data_req  input  1  request valid from IF / EX
inst_wr / data_wr  input  1  1 = write
inst_size / data_size  input  2  0=byte, 1=half, 2=word
inst_addr / data_addr  input  32  byte address
inst_wdata / data_wdata  input  32  write data
inst_wstrb / data_wstrb  input  4  byte write strobes
inst_addr_ok / data_addr_ok  output  1  request accepted this cycle
inst_data_ok / data_data_ok  output  1  response valid this cycle
inst_rdata / data_rdata  output  32  read data; 0 when the matching data_ok is 0
mem_req  output  1  downstream request valid
mem_wr, mem_size, mem_addr, mem_wdata, mem_wstrb  output  1/2/32/32/4  muxed from the granted requester
mem_addr_ok  input  1  downstream accepted mem_req
mem_data_ok  input  1  downstream response valid
mem_rdata  input  32  downstream read data

Behaviour:
- Sequential state is updated on the clk rising edge only: FSM state, owner (0=inst, 1=data), streak counter (4 bits).
- While reset==0: state=IDLE, owner=0, streak=0, and every output is forced to 0.
- FSM states:
  - IDLE: no request in flight.
  - HOLD: grant locked, waiting for mem_addr_ok.
  - WAIT: request accepted, waiting for mem_data_ok.
- Grant selection in IDLE is combinational:
  - Choose data if data_req=1, unless inst_req=1 and streak==MAX_DATA_STREAK.
  - Otherwise choose inst if inst_req=1.
- IDLE behaviour:
  - mem_req = selected requester's req; mem_* fields = selected requester's fields.
  - Granted requester's addr_ok = mem_addr_ok; the other requester's addr_ok = 0.
  - Selected with mem_addr_ok=1 -> WAIT. Selected with mem_addr_ok=0 -> HOLD. Owner latches the selection in both cases.
  - No request -> stay in IDLE, mem_req=0.
- HOLD behaviour:
  - mem_req and mem_* come from the owner only. The grant never switches even if the other requester raises req.
  - Owner's addr_ok = mem_addr_ok. mem_addr_ok=1 -> WAIT.
  - If the owner's req drops (protocol violation): mem_req=0, return to IDLE, counter unchanged.
- WAIT behaviour:
  - mem_req=0 and both addr_ok=0.
  - On mem_data_ok=1: owner's data_ok=1 and owner's rdata=mem_rdata for exactly that cycle, then -> IDLE.
  - The next grant is evaluated no earlier than the following cycle, so there is at most one outstanding transaction.
  - Unexpected mem_data_ok in IDLE or HOLD is ignored: no upstream data_ok.
- Streak counter, updated only on the acceptance cycle (IDLE or HOLD, with mem_addr_ok=1):
  - Data accepted while inst_req=1: streak = min(streak+1, MAX_DATA_STREAK).
  - Data accepted while inst_req=0: streak = 0.
  - Inst accepted: streak = 0.
- Writes behave the same as reads. Write responses also return data_ok, with rdata = mem_rdata passed through.
- Latency:
  - IDLE request with immediate mem_addr_ok: addr_ok in the same cycle.
  - data_ok is driven in the same cycle as mem_data_ok. The arbiter adds no registered delay.
- Reset mid-transaction: state returns to IDLE and any in-flight response is dropped. The downstream bridge is reset by the same reset.

Test Plan:
1. Single inst read: inst_req=1, addr=0x1C000000, mem_addr_ok=1 in the same cycle, mem_data_ok 2 cycles later with rdata=0x02800C0C -> inst_addr_ok in cycle 0, inst_data_ok with rdata=0x02800C0C, data_* outputs stay 0.
2. Simultaneous requests: inst_req and data_req both 1 in IDLE, streak=0 -> data granted (mem_addr=data_addr); inst granted only after data's data_ok returns.
3. Grant lock: data granted with mem_addr_ok held 0 for 3 cycles while inst_req=1 -> mem_addr stays data_addr all 3 cycles, inst_addr_ok=0 throughout.
4. Starvation guard: MAX_DATA_STREAK=4, inst_req held 1, data_req held 1 -> 4 data grants, then 1 inst grant, and streak returns to 0.
5. Byte store: data_wr=1, size=0, wstrb=4'b0100, wdata=0x00AB0000 -> mem_* match exactly; data_data_ok pulses once.
6. Reset in WAIT: drive reset=0 for 1 cycle before mem_data_ok -> all outputs 0, state IDLE; a later stray mem_data_ok produces no upstream data_ok.
